sqrt_scheduler: RTL and testbench

- Shares one sqrt32 core (32-bit radicand in, 16-bit root out) among N_REQ requesters, using round-robin arbitration.
- Captures the winning radicand and sequences the core: holds the core's start/reset input high while the operand settles, releases it, then waits for rdy.
- Returns the root to the winning requester as a one-cycle done pulse.
- Sits between the regex datapath clients and the single shared sqrt32 instance.

---
 rtl/sqrt_sched_pkg.sv | 9 +
 rtl/sqrt_rr_arbiter.sv | 27 ++
 rtl/sqrt_scheduler.sv | 99 +++++++++
 tb/tb_sqrt_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_sched_pkg.sv
// sqrt_sched_pkg: shared types and widths for the sqrt scheduler
package sqrt_sched_pkg;
  localparam int X_W = 32;
  localparam int Y_W = 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic int cnt_w(input int load_cycles, input int timeout);
    return $clog2((load_cycles > timeout ? load_cycles : timeout) + 1);
  endfunction
endpackage

// File: rtl/sqrt_rr_arbiter.sv
// sqrt_rr_arbiter: round-robin pick of the first request after the pointer
module sqrt_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_win,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] w_j;
  // scan circularly starting just after the last winner
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_j   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
      end
    end
    o_win = N_REQ'(o_any) << o_idx;
  end
endmodule

// File: rtl/sqrt_scheduler.sv
// sqrt_scheduler: shares one sqrt32 core among requesters, round-robin
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ*X_W-1:0] i_req_x,
  output logic [N_REQ-1:0]     o_ack,
  output logic [N_REQ-1:0]     o_done,
  output logic [Y_W-1:0]       o_result,
  output logic                 o_err,
  output logic                 o_busy,
  output logic                 o_core_start,
  output logic [X_W-1:0]       o_core_x,
  input  logic                 i_core_rdy,
  input  logic [Y_W-1:0]       i_core_y
);
  localparam int CW = cnt_w(LOAD_CYCLES, TIMEOUT);
  localparam int IW = $clog2(N_REQ);
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_idx;
  logic [N_REQ-1:0]  w_win;
  logic [IW-1:0]     w_win_idx;
  logic              w_any;
  logic [X_W-1:0]    w_x [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_x
    assign w_x[g] = i_req_x[g*X_W +: X_W];
  end
  sqrt_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );
  // sequencer: grant, hold core in start while operand settles, run, report
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ptr        <= IW'(N_REQ - 1);
      r_idx        <= '0;
      o_ack        <= '0;
      o_done       <= '0;
      o_result     <= '0;
      o_err        <= 1'b0;
      o_busy       <= 1'b0;
      o_core_start <= 1'b1;
      o_core_x     <= '0;
    end else begin
      o_ack  <= '0;
      o_done <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          o_core_x <= w_x[w_win_idx];
          r_idx    <= w_win_idx;
          r_ptr    <= w_win_idx;
          o_ack    <= w_win;
          o_busy   <= 1'b1;
          r_cnt    <= '0;
          r_state  <= LOAD;
        end
        LOAD: if (r_cnt == CW'(LOAD_CYCLES - 1)) begin
          r_cnt        <= '0;
          o_core_start <= 1'b0;
          r_state      <= RUN;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        RUN: if (r_cnt != '0 && i_core_rdy) begin
          o_result     <= i_core_y;
          o_err        <= 1'b0;
          o_done       <= N_REQ'(1) << r_idx;
          o_core_start <= 1'b1;
          r_state      <= DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          o_result     <= '0;
          o_err        <= 1'b1;
          o_done       <= N_REQ'(1) << r_idx;
          o_core_start <= 1'b1;
          r_state      <= DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb_sqrt_scheduler: randomized scoreboard bench with a behavioural sqrt32 core
module tb_sqrt_scheduler;
  localparam int N = 4;
  localparam int L = 2;
  localparam int T = 64;
  typedef struct {int idx; longint y; longint err;} exp_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*32-1:0] req_x = '0;
  logic [N-1:0]  o_ack, o_done;
  logic [15:0]   o_result;
  logic          o_err, o_busy, o_core_start;
  logic [31:0]   o_core_x;
  logic          core_rdy = 1'b0;
  logic [15:0]   core_y = '0;
  int checks = 0, errors = 0, cyc = 0;
  int acks = 0, dones = 0, ack_cyc = 0, done_cyc = 0;
  int core_k = 3, core_mode = 0, ccnt = 0;
  int mptr = N - 1;
  int ack_q[$];
  exp_t done_q[$];
  always #5 clk = ~clk;
  sqrt_scheduler #(.N_REQ(N), .LOAD_CYCLES(L), .TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_x(req_x),
    .o_ack(o_ack), .o_done(o_done), .o_result(o_result), .o_err(o_err),
    .o_busy(o_busy), .o_core_start(o_core_start), .o_core_x(o_core_x),
    .i_core_rdy(core_rdy), .i_core_y(core_y)
  );
  function automatic longint isqrt(input longint x);
    longint lo = 0, hi = 65535, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid; else hi = mid - 1;
    end
    return lo;
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // core model: mode 0 rdy k cycles after release, 1 never rdy, 2 stale rdy while held
  always @(posedge clk) begin
    logic s;
    s = o_core_start;
    #1;
    if (s) begin
      ccnt = 0;
      core_rdy = (core_mode == 2);
      core_y = 16'hBEEF;
    end else begin
      ccnt++;
      core_rdy = (core_mode != 1 && ccnt >= core_k);
      core_y = core_rdy ? 16'(isqrt(longint'(o_core_x))) : 16'hBEEF;
    end
  end
  // monitor: pop expected ack/done and compare whenever the DUT presents one
  always @(negedge clk) begin
    exp_t d;
    int e;
    if (rst_n) begin
      if (o_ack != '0) begin
        if (ack_q.size() == 0) chk("ack_unexpected", longint'(o_ack), 0);
        else begin
          e = ack_q.pop_front();
          chk("ack_onehot", longint'(o_ack), longint'(1) << e);
        end
        acks++;
        ack_cyc = cyc;
      end
      if (o_done != '0) begin
        if (done_q.size() == 0) chk("done_unexpected", longint'(o_done), 0);
        else begin
          d = done_q.pop_front();
          chk("done_onehot", longint'(o_done), longint'(1) << d.idx);
          chk("result", longint'(o_result), d.y);
          chk("err", longint'(o_err), d.err);
        end
        chk("ack_done_excl", longint'(o_ack != '0), 0);
        dones++;
        done_cyc = cyc;
      end
    end
  end
  function automatic int next_win(input logic [N-1:0] pend, input int ptr);
    for (int k = 1; k <= N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  function automatic exp_t mk(input int i, input longint x, input int mode);
    exp_t d;
    d.idx = i;
    d.y = (mode == 1) ? 0 : isqrt(x);
    d.err = (mode == 1) ? 1 : 0;
    return d;
  endfunction
  task automatic wait_cnt(input string name, input int which, input int target, input int budget);
    int c = 0;
    while (((which == 0) ? acks : dones) < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (((which == 0) ? acks : dones) < target) chk(name, 0, 1);
  endtask
  task automatic issue(input int i, input logic [31:0] x, input int k, input int mode);
    int rc, a0, d0, r;
    core_k = k;
    core_mode = mode;
    mptr = next_win(N'(1) << i, mptr);
    ack_q.push_back(mptr);
    done_q.push_back(mk(i, longint'(x), mode));
    a0 = acks;
    d0 = dones;
    @(posedge clk); #1;
    req_x[i*32 +: 32] = x;
    req[i] = 1'b1;
    rc = cyc;
    wait_cnt("ack_wait", 0, a0 + 1, 10);
    req[i] = 1'b0;
    chk("ack_latency", ack_cyc - rc, 1);
    wait_cnt("done_wait", 1, d0 + 1, T + 20);
    r = (mode == 1) ? T : k + 1;
    chk("done_latency", done_cyc - rc + 1, 1 + L + r + 1);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    chk("rst_ack", longint'(o_ack), 0);
    chk("rst_done", longint'(o_done), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_core_start", longint'(o_core_start), 1);
    ack_q.delete();
    done_q.delete();
    mptr = N - 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  initial begin
    int a0, d0, c;
    logic [31:0] xs [N];
    @(negedge clk);
    chk("rst_ack", longint'(o_ack), 0);
    chk("rst_done", longint'(o_done), 0);
    chk("rst_result", longint'(o_result), 0);
    chk("rst_err", longint'(o_err), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_core_start", longint'(o_core_start), 1);
    chk("rst_core_x", longint'(o_core_x), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(0, 32'd144, 3, 0);
    issue(2, 32'd0, 2, 0);
    issue(2, 32'd2, 1, 0);
    issue(2, 32'hFFFFFFFF, 4, 0);
    issue(2, 32'hFFFE0001, 2, 0);
    issue(1, 32'd25, 1, 1);
    issue(1, 32'd16, 2, 0);
    issue(3, 32'd169, 3, 2);
    for (int n = 0; n < 8; n++)
      issue(int'($urandom_range(0, N - 1)), $urandom, int'($urandom_range(1, 6)), 0);
    core_k = 20;
    core_mode = 0;
    mptr = next_win(4'b0010, mptr);
    ack_q.push_back(mptr);
    done_q.push_back(mk(1, 1000, 0));
    a0 = acks;
    d0 = dones;
    @(posedge clk); #1;
    req_x[32 +: 32] = 32'd1000;
    req[1] = 1'b1;
    wait_cnt("ack_wait", 0, a0 + 1, 10);
    req = '0;
    c = 0;
    while (o_core_start && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("reached_run", longint'(o_core_start), 0);
    repeat (2) @(negedge clk);
    do_reset();
    c = 0;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", dones - d0, 0);
    issue(1, 32'd9, 2, 0);
    do_reset();
    xs[0] = 32'd49;
    xs[1] = 32'd64;
    xs[2] = 32'd81;
    xs[3] = 32'd100;
    core_k = 2;
    for (int n = 0; n < 5; n++) begin
      mptr = next_win('1, mptr);
      ack_q.push_back(mptr);
      done_q.push_back(mk(mptr, longint'(xs[mptr]), 0));
    end
    a0 = acks;
    d0 = dones;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) req_x[i*32 +: 32] = xs[i];
    req = '1;
    wait_cnt("multi_ack_wait", 0, a0 + 5, 100);
    req = '0;
    wait_cnt("multi_done_wait", 1, d0 + 5, 100);
    repeat (5) @(negedge clk);
    chk("queues_empty", ack_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
